instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage between instruction memory and the core datapath. Drives
//  `pointer` (fetch PC) to instruction memory and captures `instr_in` on
//  `mem_ack`. Buffers {pc, instr} pairs in a small first-word-fall-through
//  FIFO and hands them to the core over a valid/ready interface.
//  Handles branch redirects: flushes the FIFO and discards any in-flight word.
// PARAMETERS
//  ADDR_W    32  fetch address width
//  DATA_W    32  instruction width
//  DEPTH     4   FIFO entries; power of 2, >= 2
//  RESET_PC  0   fetch address after reset
//  PC_STEP   1   pointer increment per fetched word
// PORTS
//  clk          in   1       clock
//  _reset       in   1       asynchronous, active-low reset
//  pointer      out  ADDR_W  fetch address to instruction memory
//  mem_req      out  1       fetch request; registered
//  mem_ack      in   1       instr_in valid for current pointer
//  instr_in     in   DATA_W  instruction word from memory
//  redirect     in   1       branch taken: restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W  new fetch address
//  out_valid    out  1       FIFO head valid
//  out_ready    in   1       core accepts head
//  out_instr    out  DATA_W  head instruction
//  out_pc       out  ADDR_W  address of head instruction
// BEHAVIOUR
//  Reset (async, immediate, no clock needed):
//   - pointer=RESET_PC, next_pc=RESET_PC, mem_req=0
//   - FIFO empty; out_valid=0; out_instr=0; out_pc=0; state=IDLE
//  Memory protocol:
//   - Once asserted, mem_req and pointer stay stable until a cycle with
//     mem_ack=1. Only one request is outstanding.
//   - Ack is allowed in the same cycle mem_req is first seen.
//   - mem_ack is ignored while mem_req=0.
//  States:
//   - IDLE: mem_req=0. Go to REQ when count<DEPTH and no redirect.
//   - REQ: mem_req=1.
//      - On ack: push {pointer, instr_in}; pointer += PC_STEP.
//      - After the ack, stay in REQ if post-update count<DEPTH, else IDLE.
//      - Back-to-back acks give 1 instruction per cycle.
//   - DROP: mem_req=1, pointer held.
//      - On ack: discard instr_in; pointer <= next_pc; go to IDLE.
//  Redirect (highest priority, any state):
//   - Always: FIFO flushed, next_pc <= redirect_pc.
//   - IDLE, or REQ with mem_ack=1: the acked word is dropped,
//     pointer <= redirect_pc, go to IDLE.
//   - REQ with mem_ack=0: go to DROP.
//   - DROP: updates next_pc only; the last redirect wins.
//   - An out handshake in the same cycle as a redirect counts as consumed.
//  FIFO:
//   - push only on an accepted ack; pop on out_valid && out_ready.
//   - Push and pop in the same cycle leaves count unchanged.
//   - Requests are issued only with a free slot, so overflow is impossible.
//   - out_valid = count!=0; out_instr/out_pc reflect the head combinationally.
//  Latency: ack in cycle N -> out_valid with that word in cycle N+1.
//  Arithmetic: pointer increments mod 2^ADDR_W; wrap to 0 is legal.
//   Pointers/count use $clog2(DEPTH)+1 bits.
// TESTING
//  1. Release reset, mem_ack=1, out_ready=1
//     -> pointer 0,1,2,...; out_pc 0 valid one cycle after first ack;
//        1 instr/cycle.
//  2. out_ready=0, mem_ack=1
//     -> 4 words buffered, mem_req=0, pointer=4;
//        set ready -> out_pc 0,1,2,3 in order, fetch resumes at 4.
//  3. Ack delayed 3 cycles, redirect to 0x100 in the second wait cycle
//     -> mem_req/pointer held until ack, word dropped, out_valid=0;
//        next req pointer=0x100; first out_pc=0x100.
//  4. Redirect to 0x200 in the same cycle as an ack at pointer=5
//     -> word at 5 never appears; next pointer=0x200.
//  5. RESET_PC=32'hFFFF_FFFF, one ack
//     -> out_pc=0xFFFFFFFF, next pointer=0.
//  6. Assert _reset low mid-wait, between clock edges
//     -> mem_req=0, out_valid=0, pointer=RESET_PC immediately.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: issues fetch addresses to instruction memory and queues
// {pc, instr} pairs in a small FWFT FIFO for the core, with redirect flush.
module instr_fetch #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(1)
) (
   input  logic              clk,
   input  logic              _reset,
   output logic [ADDR_W-1:0] pointer,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] instr_in,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] next_pc_q, next_pc_d;
   logic              mem_req_q, mem_req_d;
   logic [CW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     rd_q, rd_d;
   entry_t            mem_q [DEPTH];

   logic [CW-1:0]     count;
   logic [CW-1:0]     cnt_ack;
   logic              pop;
   logic              push;
   entry_t            head;

   assign count     = wr_q - rd_q;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   // occupancy after an accepted ack this cycle
   assign cnt_ack   = count + CW'(1) - CW'(pop);
   assign head      = mem_q[rd_q[AW-1:0]];
   assign out_pc    = out_valid ? head.pc : '0;
   assign out_instr = out_valid ? head.instr : '0;
   assign pointer   = ptr_q;
   assign mem_req   = mem_req_q;

   // next-state: fetch sequencing, redirect handling and FIFO pointers
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      next_pc_d = next_pc_q;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               ptr_d = redirect_pc;
            end else if (count < FULL) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               if (mem_ack) begin
                  ptr_d   = redirect_pc;
                  state_d = IDLE;
               end else begin
                  state_d = DROP;
               end
            end else if (mem_ack) begin
               push  = 1'b1;
               ptr_d = ptr_q + PC_STEP;
               if (cnt_ack >= FULL) begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (mem_ack) begin
               ptr_d   = redirect ? redirect_pc : next_pc_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect) begin
         next_pc_d = redirect_pc;
      end
      mem_req_d = (state_d != IDLE);
      wr_d      = wr_q + CW'(push);
      rd_d      = rd_q + CW'(pop);
      if (redirect) begin
         wr_d = '0;
         rd_d = '0;
      end
   end

   // control state and registered memory request
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q   <= IDLE;
         ptr_q     <= RESET_PC;
         next_pc_q <= RESET_PC;
         mem_req_q <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         next_pc_q <= next_pc_d;
         mem_req_q <= mem_req_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
      end
   end

   // FIFO storage; contents are qualified by count so need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= '{pc: ptr_q, instr: instr_in};
      end
   end

endmodule
